simon_key_schedule: RTL and testbench
=====================================

Name: simon_key_schedule

Overview:
- Iterative round-key generator for SIMON 128/128 (n=64, m=2, T=68, constant sequence z2).
- Sits directly upstream of the round datapath inside top_simon.
- Loads a 128-bit master key, then streams one 64-bit round key per accepted handshake, k[0] through k[67].
- Consumer back-pressure is supported, so the datapath can stall between rounds.

Parameters:
ROUNDS, 68, number of round keys emitted per key load (fixed for 128/128; values other than 68 are unsupported).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  load key_i and begin expansion; sampled only in IDLE
key_i  in  128  master key; key_i[63:0]=k[0], key_i[127:64]=k[1]
rk_ready_i  in  1  consumer can take rk_o this cycle
rk_valid_o  out  1  rk_o/rk_idx_o hold a valid round key
rk_o  out  64  round key k[rk_idx_o]
rk_idx_o  out  7  index of presented round key, 0..ROUNDS-1
busy_o  out  1  high while in RUN
done_o  out  1  one-cycle pulse after final key accepted

Behaviour:
- Reset (async assert, sync deassert by clk domain):
  - state=IDLE.
  - All outputs 0, including rk_o=0 and rk_idx_o=0.
  - Internal ka, kb and zidx cleared.
- State IDLE:
  - rk_valid_o=0, busy_o=0.
  - On start_i=1: ka<=key_i[63:0], kb<=key_i[127:64], idx<=0, zidx<=0, go to RUN.
- State RUN:
  - rk_valid_o=1, busy_o=1, rk_o=ka, rk_idx_o=idx.
  - Latency: the first key is visible in the cycle after start_i is sampled.
- Handshake:
  - A transfer occurs when rk_valid_o && rk_ready_i.
  - With no transfer, rk_o and rk_idx_o hold stable. No changes without a transfer.
- On each transfer:
  - ka<=kb, kb<=knext, idx<=idx+1.
  - zidx<=(zidx==61)?0:zidx+1.
  - Back-to-back transfers sustain 1 key/cycle.
- Next-key function (all 64-bit, rotations mod 64):
  - t=ROR(kb,3) ^ ROR(kb,4).
  - knext = ~ka ^ t ^ {63'b0, Z2[61-zidx]} ^ 64'h3.
  - Equivalently, knext = C ^ z ^ ka ^ t with C=64'hFFFF_FFFF_FFFF_FFFC.
- z wrap: the key at index i+2 uses z[i mod 62]. zidx wraps after index 61 is used, so k[64] uses z[0] again.
- Termination: a transfer with idx==ROUNDS-1 moves to IDLE. In the next cycle:
  - done_o=1 for exactly one cycle.
  - rk_valid_o=0, busy_o=0.
  - rk_o and rk_idx_o keep their last values.
  - knext is computed but discarded.
- Simultaneous events:
  - start_i while in RUN is ignored; no restart.
  - start_i in the done_o cycle (IDLE) is accepted normally.
  - rk_ready_i while in IDLE has no effect.
- Reset mid-operation: immediate return to IDLE with all outputs 0. done_o is not pulsed.
- Key stability: key_i is sampled only at start. Later changes to key_i do not affect the key stream in flight.

Decomposition:
- simon_pkg holds:
  - typedef logic [63:0] word_t
  - localparam ROUNDS_128=68
  - localparam Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011, where z[j]=Z2[61-j]
  - localparam word_t C_CONST = 64'hFFFF_FFFF_FFFF_FFFC
  - enum state_t {IDLE, RUN}
  - function automatic ror64(word_t x, int r)
- One natural sub-module is simon_key_next: a combinational knext function of (ka, kb, zbit). It is reusable by a future unrolled/pipelined schedule and the golden model.

Test Plan:
- Reset behaviour: hold rst_n=0, drive start_i=1 -> rk_valid_o=0, busy_o=0, done_o=0, rk_o=0. Deassert reset -> still IDLE until start_i is sampled.
- Full stream, standard vector: key_i=128'h0f0e0d0c0b0a09080706050403020100, rk_ready_i=1 constantly.
  - rk_o[0]=64'h0706050403020100 with rk_idx_o=0.
  - rk_o[1]=64'h0f0e0d0c0b0a0908.
  - All 68 keys match the C golden model.
  - done_o pulses exactly 68 cycles after the first valid.
  - The datapath fed with pt 128'h63736564207372656c6c657661727420 yields ct 128'h49681b1e1e54fe3f65aa832af84e0bbc.
- Back-pressure: random rk_ready_i with about 40% duty -> rk_o and rk_idx_o stable while not ready; the same 68-key sequence is produced; idx never skips.
- z wrap: check rk_idx_o=63 and 64 against the model (uses z[61] then z[0]) with a stall inserted exactly at idx 61/62 -> correct keys.
- start_i in RUN: pulse start_i with a different key at idx 10 -> ignored; the sequence continues from the original key. start_i in the done_o cycle -> a new stream begins next cycle with idx 0.
- Reset mid-stream: assert rst_n=0 asynchronously at idx 30 (between clock edges) -> outputs 0 immediately, no done_o. A restart with the same key reproduces k[0..67].

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON 128/128 key schedule.
package simon_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned IDX_W      = 7;
    localparam int unsigned ZIDX_W     = 6;
    localparam int unsigned Z_LEN      = 62;
    localparam int unsigned ROUNDS_128 = 68;

    typedef logic [WORD_W-1:0] word_t;

    // z2 constant sequence, z[j] = Z2[61-j]
    localparam logic [Z_LEN-1:0] Z2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;

    localparam word_t C_CONST = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic word_t ror64(word_t x, int r);
        return (x >> r) | (x << (WORD_W - r));
    endfunction

endpackage

// File: rtl/simon_key_next.sv
// Combinational next-round-key function for SIMON 128/128 (m=2).
module simon_key_next
    import simon_pkg::*;
(
    input  word_t ka,
    input  word_t kb,
    input  logic  zbit,
    output word_t knext_c
);

    assign knext_c = C_CONST ^ WORD_W'(zbit) ^ ka ^ ror64(kb, 3) ^ ror64(kb, 4);

endmodule

// File: rtl/simon_key_schedule.sv
// Iterative SIMON 128/128 round-key generator with valid/ready streaming output.
module simon_key_schedule
    import simon_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [127:0]     key_i,
    input  logic             rk_ready_i,
    output logic             rk_valid_o,
    output logic [63:0]      rk_o,
    output logic [IDX_W-1:0] rk_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t            state, state_next;
    word_t             ka, kb;
    logic [IDX_W-1:0]  idx;
    logic [ZIDX_W-1:0] zidx;
    logic              load_c, xfer_c, final_c;
    logic              zbit_c;
    word_t             knext_c;

    assign zbit_c = Z2[ZIDX_W'(Z_LEN - 1) - zidx];

    simon_key_next u_key_next (
        .ka      (ka),
        .kb      (kb),
        .zbit    (zbit_c),
        .knext_c (knext_c)
    );

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        xfer_c     = 1'b0;
        final_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    load_c     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (rk_ready_i) begin
                    xfer_c = 1'b1;
                    if (idx == IDX_W'(ROUNDS - 1)) begin
                        final_c    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The final transfer leaves ka/idx untouched so the last key stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ka         <= '0;
            kb         <= '0;
            idx        <= '0;
            zidx       <= '0;
            rk_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= state_next;
            rk_valid_o <= (state_next == RUN);
            busy_o     <= (state_next == RUN);
            done_o     <= final_c;
            if (load_c) begin
                ka   <= key_i[63:0];
                kb   <= key_i[127:64];
                idx  <= '0;
                zidx <= '0;
            end else if (xfer_c && !final_c) begin
                ka   <= kb;
                kb   <= knext_c;
                idx  <= idx + IDX_W'(1);
                zidx <= (zidx == ZIDX_W'(Z_LEN - 1)) ? '0 : zidx + ZIDX_W'(1);
            end
        end
    end

    assign rk_o     = ka;
    assign rk_idx_o = idx;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Scoreboard bench for simon_key_schedule against an independent SIMON key/round model.
module tb_simon_key_schedule;

    localparam int NR = 68;
    localparam logic [61:0] ZSEQ =
        62'b10101111011100000011010010011000101000010001111110010110110011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [127:0] key_i;
    logic         rk_ready_i;
    logic         rk_valid_o;
    logic [63:0]  rk_o;
    logic [6:0]   rk_idx_o;
    logic         busy_o;
    logic         done_o;

    simon_key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .key_i      (key_i),
        .rk_ready_i (rk_ready_i),
        .rk_valid_o (rk_valid_o),
        .rk_o       (rk_o),
        .rk_idx_o   (rk_idx_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  idx;
        logic [63:0] key;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model_k[NR];
    logic [63:0] seen[NR];
    int          total = 0;
    int          bad   = 0;

    localparam logic [127:0] K0 = 128'h0f0e0d0c0b0a09080706050403020100;

    function automatic logic [63:0] rr(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic logic [63:0] rl(input logic [63:0] x, input int r);
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic void gen_model(input logic [127:0] k);
        logic [61:0] zs;
        zs = ZSEQ;
        model_k[0] = k[63:0];
        model_k[1] = k[127:64];
        for (int i = 2; i < NR; i++) begin
            model_k[i] = ~model_k[i-2] ^ rr(model_k[i-1], 3) ^ rr(model_k[i-1], 4)
                       ^ 64'(zs[61 - ((i - 2) % 62)]) ^ 64'h3;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_stream(input logic [127:0] k);
        exp_t e;
        gen_model(k);
        for (int i = 0; i < NR; i++) begin
            e.idx = 7'(i);
            e.key = model_k[i];
            sb.push_back(e);
        end
        start_i = 1'b1;
        key_i   = k;
    endtask

    // mode 0: always ready, 1: ~40% ready, 2: stall at idx 61/62, 3: start pulse at idx 10
    task automatic drain(input int mode, input int stop_idx);
        int          cyc   = 0;
        int          stall = 0;
        logic        r;
        logic [63:0] lastk = '0;
        logic [6:0]  lasti = '0;
        while (sb.size() > 0) begin
            @(negedge clk);
            start_i = 1'b0;
            key_i   = {$urandom, $urandom, $urandom, $urandom};
            cyc++;
            if (cyc > 1000) begin
                check("timeout_queue_left", 64'(sb.size()), 64'd0);
                sb.delete();
                return;
            end
            check("valid", 64'(rk_valid_o), 64'd1);
            check("busy", 64'(busy_o), 64'd1);
            check("done_low", 64'(done_o), 64'd0);
            check("rk", rk_o, sb[0].key);
            check("rk_idx", 64'(rk_idx_o), 64'(sb[0].idx));
            if (int'(sb[0].idx) == stop_idx) return;
            case (mode)
                1:       r = ($urandom_range(0, 99) < 40);
                2:       r = !((sb[0].idx == 7'd61 || sb[0].idx == 7'd62) && stall < 2);
                default: r = 1'b1;
            endcase
            if (mode == 3 && sb[0].idx == 7'd10) begin
                start_i = 1'b1;
                key_i   = ~K0;
            end
            rk_ready_i = r;
            if (r) begin
                lastk = sb[0].key;
                lasti = sb[0].idx;
                seen[sb[0].idx] = rk_o;
                void'(sb.pop_front());
                stall = 0;
            end else begin
                stall++;
            end
        end
        @(negedge clk);
        cyc++;
        check("done_pulse", 64'(done_o), 64'd1);
        check("done_valid_low", 64'(rk_valid_o), 64'd0);
        check("done_busy_low", 64'(busy_o), 64'd0);
        check("done_rk_hold", rk_o, lastk);
        check("done_idx_hold", 64'(rk_idx_o), 64'(lasti));
        if (mode == 0) check("done_latency", 64'(cyc - 1), 64'd68);
    endtask

    task automatic check_ct;
        logic [63:0] x, y, t;
        x = 64'h6373656420737265;
        y = 64'h6c6c657661727420;
        for (int i = 0; i < NR; i++) begin
            t = x;
            x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ seen[i];
            y = t;
        end
        check("ct_hi", x, 64'h49681b1e1e54fe3f);
        check("ct_lo", y, 64'h65aa832af84e0bbc);
    endtask

    initial begin
        logic [127:0] k1;
        k1         = {$urandom, $urandom, $urandom, $urandom};
        rst_n      = 1'b0;
        start_i    = 1'b1;
        key_i      = K0;
        rk_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(rk_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_rk", rk_o, 64'd0);
        check("rst_idx", 64'(rk_idx_o), 64'd0);
        start_i = 1'b0;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_valid", 64'(rk_valid_o), 64'd0);
        check("idle_busy", 64'(busy_o), 64'd0);

        // Standard vector, full speed, then the datapath check on the captured keys
        start_stream(K0);
        drain(0, NR);
        check("k0_vec", seen[0], 64'h0706050403020100);
        check("k1_vec", seen[1], 64'h0f0e0d0c0b0a0908);
        check_ct();

        // Restart in the done cycle, random back-pressure
        start_stream(K0);
        drain(1, NR);

        // Stall across the z wrap
        start_stream(k1);
        drain(2, NR);

        // start_i during RUN must be ignored
        start_stream(K0);
        drain(3, NR);

        // Asynchronous reset mid-stream, then a clean restart
        start_stream(k1);
        drain(0, 30);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rk_valid_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_done", 64'(done_o), 64'd0);
        check("mid_rst_rk", rk_o, 64'd0);
        check("mid_rst_idx", 64'(rk_idx_o), 64'd0);
        sb.delete();
        @(negedge clk);
        check("mid_rst_no_done", 64'(done_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(rk_valid_o), 64'd0);
        check("post_rst_no_done", 64'(done_o), 64'd0);
        start_stream(k1);
        drain(0, NR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
